br_update_queue: RTL and testbench

BR_UPDATE_QUEUE -- requirements
Module: br_update_queue

---
 rtl/br_update_queue.sv | 131 +++++++++++++
 tb/tb_br_update_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_update_queue.sv
// Branch-update queue: buffers resolved branch results from execute and feeds them,
// one per cycle and in order, to the predictor's counter write port.
module br_update_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ENQ_WIDTH  = 2,
    parameter int unsigned IDX_WIDTH  = 10,
    parameter int unsigned HIST_WIDTH = 4,
    parameter int unsigned CTR_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  logic [ENQ_WIDTH-1:0]            enqValid,
    input  logic [ENQ_WIDTH*IDX_WIDTH-1:0]  enqIdx,
    input  logic [ENQ_WIDTH*HIST_WIDTH-1:0] enqHist,
    input  logic [ENQ_WIDTH*CTR_WIDTH-1:0]  enqCtr,
    input  logic [ENQ_WIDTH-1:0]            enqTaken,
    output logic                            enqReady,
    output logic                            deqValid,
    input  logic                            deqReady,
    output logic [IDX_WIDTH-1:0]            deqIdx,
    output logic [HIST_WIDTH-1:0]           deqHist,
    output logic [CTR_WIDTH-1:0]            deqCtr,
    input  logic                            flush,
    output logic [$clog2(DEPTH):0]          count,
    output logic [7:0]                      dropCount
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CTR_WIDTH-1:0] CtrMax = {CTR_WIDTH{1'b1}};

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      drop_q, drop_d;

    logic [IDX_WIDTH-1:0]  idx_mem   [DEPTH];
    logic [HIST_WIDTH-1:0] hist_mem  [DEPTH];
    logic [CTR_WIDTH-1:0]  ctr_mem   [DEPTH];
    logic                  taken_mem [DEPTH];

    logic [PtrW-1:0]      slot_ofs [ENQ_WIDTH];
    logic [CntW-1:0]      n_valid;
    logic                 enq_fire;
    logic                 deq_fire;
    logic [8:0]           drop_sum;
    logic [CTR_WIDTH-1:0] head_ctr;

    // Each valid slot lands at tail + (number of valid slots before it), closing gaps.
    always_comb begin
        n_valid = '0;
        for (int s = 0; s < ENQ_WIDTH; s++) begin
            slot_ofs[s] = n_valid[PtrW-1:0];
            n_valid     = n_valid + CntW'(enqValid[s]);
        end
    end

    always_comb begin
        enqReady = count_q <= CntW'(DEPTH - ENQ_WIDTH);
        deqValid = count_q != '0;
        enq_fire = enqReady && !flush;
        deq_fire = deqValid && deqReady && !flush;
        drop_sum = {1'b0, drop_q} + 9'(n_valid);
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enqReady) begin
                tail_d  = tail_q + n_valid[PtrW-1:0];
                count_d = count_q + n_valid;
            end else begin
                drop_d = (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];
            end
            if (deq_fire) begin
                head_d  = head_q + PtrW'(1);
                count_d = count_d - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Storage is deliberately unreset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int s = 0; s < ENQ_WIDTH; s++) begin
                if (enqValid[s]) begin
                    idx_mem[tail_q + slot_ofs[s]]   <= enqIdx[s*IDX_WIDTH +: IDX_WIDTH];
                    hist_mem[tail_q + slot_ofs[s]]  <= enqHist[s*HIST_WIDTH +: HIST_WIDTH];
                    ctr_mem[tail_q + slot_ofs[s]]   <= enqCtr[s*CTR_WIDTH +: CTR_WIDTH];
                    taken_mem[tail_q + slot_ofs[s]] <= enqTaken[s];
                end
            end
        end
    end

    always_comb begin
        head_ctr = ctr_mem[head_q];
        deqIdx   = idx_mem[head_q];
        deqHist  = hist_mem[head_q];
        deqCtr   = head_ctr;
        if (taken_mem[head_q]) begin
            if (head_ctr != CtrMax) deqCtr = head_ctr + CTR_WIDTH'(1);
        end else begin
            if (head_ctr != '0) deqCtr = head_ctr - CTR_WIDTH'(1);
        end
    end

    assign count     = count_q;
    assign dropCount = drop_q;

endmodule

// File: tb/tb_br_update_queue.sv
// Bench for br_update_queue: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_br_update_queue;

    localparam int DEPTH = 8;
    localparam int ENQ_WIDTH = 2;
    localparam int IDX_WIDTH = 10;
    localparam int HIST_WIDTH = 4;
    localparam int CTR_WIDTH = 2;
    localparam int CTR_MAX = (1 << CTR_WIDTH) - 1;

    logic clk = 0;
    logic rstN;
    logic [ENQ_WIDTH-1:0] enqValid;
    logic [ENQ_WIDTH*IDX_WIDTH-1:0] enqIdx;
    logic [ENQ_WIDTH*HIST_WIDTH-1:0] enqHist;
    logic [ENQ_WIDTH*CTR_WIDTH-1:0] enqCtr;
    logic [ENQ_WIDTH-1:0] enqTaken;
    logic enqReady, deqValid, deqReady, flush;
    logic [IDX_WIDTH-1:0] deqIdx;
    logic [HIST_WIDTH-1:0] deqHist;
    logic [CTR_WIDTH-1:0] deqCtr;
    logic [$clog2(DEPTH):0] count;
    logic [7:0] dropCount;

    br_update_queue #(
        .DEPTH(DEPTH), .ENQ_WIDTH(ENQ_WIDTH), .IDX_WIDTH(IDX_WIDTH),
        .HIST_WIDTH(HIST_WIDTH), .CTR_WIDTH(CTR_WIDTH)
    ) dut (
        .clk(clk), .rstN(rstN), .enqValid(enqValid), .enqIdx(enqIdx), .enqHist(enqHist),
        .enqCtr(enqCtr), .enqTaken(enqTaken), .enqReady(enqReady), .deqValid(deqValid),
        .deqReady(deqReady), .deqIdx(deqIdx), .deqHist(deqHist), .deqCtr(deqCtr),
        .flush(flush), .count(count), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of pending results and a drop tally.
    typedef struct {
        int idx;
        int hist;
        int ctr;
        bit taken;
    } ent_t;
    ent_t mq[$];
    int m_drop = 0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mq.delete();
            m_drop = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            bit room;
            bit pop;
            room = mq.size() <= DEPTH - ENQ_WIDTH;
            pop = (mq.size() != 0) && deqReady;
            if (pop) void'(mq.pop_front());
            for (int s = 0; s < ENQ_WIDTH; s++) begin
                if (enqValid[s]) begin
                    if (room) begin
                        ent_t e;
                        e.idx = int'(enqIdx[s*IDX_WIDTH +: IDX_WIDTH]);
                        e.hist = int'(enqHist[s*HIST_WIDTH +: HIST_WIDTH]);
                        e.ctr = int'(enqCtr[s*CTR_WIDTH +: CTR_WIDTH]);
                        e.taken = enqTaken[s];
                        mq.push_back(e);
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("enqReady", int'(enqReady), int'(mq.size() <= DEPTH - ENQ_WIDTH));
        check("deqValid", int'(deqValid), int'(mq.size() != 0));
        check("count", int'(count), mq.size());
        check("dropCount", int'(dropCount), m_drop);
        if (mq.size() != 0) begin
            int ec;
            ec = mq[0].taken ? ((mq[0].ctr + 1 > CTR_MAX) ? CTR_MAX : mq[0].ctr + 1)
                             : ((mq[0].ctr == 0) ? 0 : mq[0].ctr - 1);
            check("deqIdx", int'(deqIdx), mq[0].idx);
            check("deqHist", int'(deqHist), mq[0].hist);
            check("deqCtr", int'(deqCtr), ec);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input bit v, input int idx, input int ctr, input bit t);
        enqValid[s] = v;
        enqIdx[s*IDX_WIDTH +: IDX_WIDTH] = IDX_WIDTH'(idx);
        enqHist[s*HIST_WIDTH +: HIST_WIDTH] = HIST_WIDTH'(idx + 3);
        enqCtr[s*CTR_WIDTH +: CTR_WIDTH] = CTR_WIDTH'(ctr);
        enqTaken[s] = t;
    endtask

    task automatic idle();
        enqValid = '0;
        flush = 0;
    endtask

    initial begin
        rstN = 0;
        enqValid = '0; enqIdx = '0; enqHist = '0; enqCtr = '0; enqTaken = '0;
        deqReady = 0; flush = 0;
        step(); step();
        check("rst_count", int'(count), 0);
        check("rst_deqValid", int'(deqValid), 0);
        check("rst_enqReady", int'(enqReady), 1);
        check("rst_dropCount", int'(dropCount), 0);
        rstN = 1;
        step();

        // Two results in one cycle; second counter saturates at the top.
        set_slot(0, 1, 5, 1, 1);
        set_slot(1, 1, 9, 3, 1);
        deqReady = 1;
        step(); idle();
        check("pair_idx0", int'(deqIdx), 5);
        check("pair_ctr0", int'(deqCtr), 2);
        check("pair_count", int'(count), 2);
        step();
        check("pair_idx1", int'(deqIdx), 9);
        check("pair_ctr1", int'(deqCtr), 3);
        step();
        check("pair_empty", int'(deqValid), 0);

        // Only slot 1 valid: compacted into the tail; counter floors at 0.
        deqReady = 0;
        set_slot(0, 0, 100, 2, 1);
        set_slot(1, 1, 7, 0, 0);
        step(); idle();
        check("slot1_idx", int'(deqIdx), 7);
        check("slot1_ctr", int'(deqCtr), 0);
        check("slot1_count", int'(count), 1);
        deqReady = 1;
        step();
        check("slot1_drain", int'(count), 0);

        // Fill to DEPTH with no dequeues, then overflow drops a full pair.
        deqReady = 0;
        for (int c = 0; c < 5; c++) begin
            set_slot(0, 1, 16 + 2 * c, c % 4, c[0]);
            set_slot(1, 1, 17 + 2 * c, (c + 1) % 4, !c[0]);
            check("fill_ready", int'(enqReady), (c < 4) ? 1 : 0);
            step();
            check("fill_count", int'(count), (c < 4) ? 2 * (c + 1) : 8);
        end
        idle();
        check("fill_drop", int'(dropCount), 2);
        deqReady = 1;
        for (int k = 0; k < 8; k++) begin
            check("order_idx", int'(deqIdx), 16 + k);
            step();
        end
        check("order_empty", int'(count), 0);

        // count=7: single enqueue dropped while a dequeue still happens.
        deqReady = 0;
        for (int c = 0; c < 4; c++) begin
            set_slot(0, c < 3, 40 + c, 1, 1);
            set_slot(1, 1, 50 + c, 2, 0);
            step();
        end
        idle();
        check("seven_count", int'(count), 7);
        check("seven_ready", int'(enqReady), 0);
        set_slot(0, 1, 60, 1, 1);
        set_slot(1, 0, 61, 1, 1);
        deqReady = 1;
        step(); idle();
        check("seven_after", int'(count), 6);
        check("seven_drop", int'(dropCount), 3);
        flush = 1;
        step(); idle();

        // Flush with concurrent enqueue and dequeue request.
        deqReady = 0;
        for (int c = 0; c < 3; c++) begin
            set_slot(0, 1, 70 + c, 0, 1);
            set_slot(1, c < 2, 80 + c, 3, 0);
            step();
        end
        check("flush_pre", int'(count), 5);
        set_slot(0, 1, 90, 0, 1);
        set_slot(1, 1, 91, 0, 1);
        deqReady = 1;
        flush = 1;
        step(); idle();
        check("flush_count", int'(count), 0);
        check("flush_deqValid", int'(deqValid), 0);
        check("flush_drop", int'(dropCount), 3);

        // Asynchronous reset mid-operation.
        deqReady = 0;
        set_slot(0, 1, 11, 1, 1); set_slot(1, 1, 12, 1, 1);
        step();
        set_slot(1, 0, 0, 0, 0);
        step(); idle();
        check("prerst_count", int'(count), 3);
        rstN = 0;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_deqValid", int'(deqValid), 0);
        check("arst_enqReady", int'(enqReady), 1);
        check("arst_drop", int'(dropCount), 0);
        @(posedge clk);
        #1;
        rstN = 1;
        set_slot(0, 1, 4, 2, 0);
        deqReady = 1;
        step(); idle();
        check("postrst_idx", int'(deqIdx), 4);
        check("postrst_ctr", int'(deqCtr), 1);
        step();
        check("postrst_empty", int'(count), 0);

        // Mixed traffic that wraps the pointers several times.
        for (int c = 0; c < 40; c++) begin
            set_slot(0, c[0], 200 + c, c % 4, c[1]);
            set_slot(1, c[1], 300 + c, (c + 2) % 4, c[2]);
            deqReady = (c % 3) != 0;
            step();
        end
        idle();
        deqReady = 1;
        for (int c = 0; c < 10; c++) step();
        check("mix_empty", int'(count), 0);

        // Drop counter saturates at 255.
        deqReady = 0;
        flush = 1;
        step();
        flush = 0;
        for (int c = 0; c < 134; c++) begin
            set_slot(0, 1, c, 1, 1);
            set_slot(1, 1, c + 1, 1, 0);
            step();
        end
        idle();
        check("sat_drop", int'(dropCount), 255);
        check("sat_count", int'(count), 8);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
